// File: rtl/video_pkg.sv
// Shared video definitions for the OV5640 DVP capture path: pixel width,
// capture FSM state encoding, default resolution and RGB565 packing helper.
package video_pkg;

  localparam int RGB565_W      = 16;
  localparam int DEFAULT_WIDTH = 640;
  localparam int DEFAULT_DEPTH = 480;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SKIP       = 3'd1,
    ST_WAIT_FRAME = 3'd2,
    ST_CAPTURE    = 3'd3,
    ST_DROP       = 3'd4
  } cap_state_e;

  // First byte on the bus is the high byte of the RGB565 word.
  function automatic logic [RGB565_W-1:0] pack_rgb565(input logic [7:0] hi,
                                                      input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/dvp_byte_packer.sv
// DVP input stage: registers VSYNC/HREF/D once, tracks the byte phase within
// a line and emits one registered pixel-valid pulse per byte pair, plus a
// registered end-of-line pulse aligned after the last pixel of the line.
module dvp_byte_packer
  import video_pkg::*;
(
  input  logic                clk_i,
  input  logic                resetn_i,
  input  logic                clear_i,
  input  logic                cam_vsync_i,
  input  logic                cam_href_i,
  input  logic [7:0]          cam_data_i,
  output logic                vsync_o,
  output logic                pix_valid_o,
  output logic [RGB565_W-1:0] pix_data_o,
  output logic                line_end_o
);

  logic                s_vsync_q;
  logic                s_href_q;
  logic [7:0]          s_data_q;
  logic                href_dly_q;
  logic                phase_q;
  logic                phase_d;
  logic [7:0]          hi_q;
  logic                pix_fire;
  logic                pix_valid_q;
  logic [RGB565_W-1:0] pix_data_q;
  logic                line_end_q;

  // Phase restarts on every line (and on capture entry) so a trailing odd
  // byte never pairs with the first byte of the next line.
  always_comb begin
    pix_fire = s_href_q & phase_q;
    phase_d  = phase_q;
    if (clear_i || !s_href_q) begin
      phase_d = 1'b0;
    end else begin
      phase_d = ~phase_q;
    end
  end

  // Single register stage on the raw camera pins.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      s_vsync_q <= 1'b0;
      s_href_q  <= 1'b0;
      s_data_q  <= 8'h00;
    end else begin
      s_vsync_q <= cam_vsync_i;
      s_href_q  <= cam_href_i;
      s_data_q  <= cam_data_i;
    end
  end

  // Byte pairing, pixel formation and href falling-edge detection.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      href_dly_q  <= 1'b0;
      phase_q     <= 1'b0;
      hi_q        <= 8'h00;
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
      line_end_q  <= 1'b0;
    end else begin
      href_dly_q  <= s_href_q;
      line_end_q  <= href_dly_q & ~s_href_q;
      phase_q     <= phase_d;
      pix_valid_q <= pix_fire & ~clear_i;
      if (s_href_q && !phase_q) begin
        hi_q <= s_data_q;
      end
      if (pix_fire) begin
        pix_data_q <= pack_rgb565(hi_q, s_data_q);
      end
    end
  end

  assign vsync_o     = s_vsync_q;
  assign pix_valid_o = pix_valid_q;
  assign pix_data_o  = pix_data_q;
  assign line_end_o  = line_end_q;

endmodule

// File: rtl/ov5640_dvp_capture.sv
// OV5640 DVP capture front end: frame sequencing (settle skip, capture, drop
// on overflow), cropping to the programmed resolution and FIFO write port.
module ov5640_dvp_capture
  import video_pkg::*;
#(
  parameter int DATA_WIDTH  = RGB565_W,
  parameter int CNT_WIDTH   = 16,
  parameter int SKIP_FRAMES = 2
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
  input  logic                  enable_i,
  input  logic [15:0]           resolution_width_i,
  input  logic [15:0]           resolution_depth_i,
  input  logic                  cam_vsync_i,
  input  logic                  cam_href_i,
  input  logic [7:0]            cam_data_i,
  input  logic                  fifo_cam_full,
  output logic                  fifo_cam_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_cam_din,
  output logic                  frame_start_o,
  output logic                  frame_done_o,
  output logic [15:0]           frame_cnt_o,
  output logic                  overflow_o,
  output logic                  busy_o
);

  cap_state_e            state_q;
  logic [CNT_WIDTH-1:0]  skip_cnt_q;
  logic [CNT_WIDTH-1:0]  width_sh_q;
  logic [CNT_WIDTH-1:0]  depth_sh_q;
  logic [CNT_WIDTH-1:0]  col_q;
  logic [CNT_WIDTH-1:0]  col_d;
  logic [CNT_WIDTH-1:0]  row_q;
  logic [CNT_WIDTH-1:0]  row_d;
  logic                  vsync_dly_q;
  logic                  wr_en_q;
  logic [DATA_WIDTH-1:0] din_q;
  logic                  frame_start_q;
  logic                  frame_done_q;
  logic [15:0]           frame_cnt_q;
  logic                  overflow_q;

  logic                  s_vsync;
  logic                  pix_valid;
  logic [RGB565_W-1:0]   pix_data;
  logic                  line_end;
  logic                  vs_fall;
  logic                  vs_rise;
  logic                  write_due;
  logic                  capture_entry;

  dvp_byte_packer u_packer (
    .clk_i       (clk_i),
    .resetn_i    (resetn_i),
    .clear_i     (capture_entry),
    .cam_vsync_i (cam_vsync_i),
    .cam_href_i  (cam_href_i),
    .cam_data_i  (cam_data_i),
    .vsync_o     (s_vsync),
    .pix_valid_o (pix_valid),
    .pix_data_o  (pix_data),
    .line_end_o  (line_end)
  );

  // Frame edges, crop window test and next column/row counts.
  always_comb begin
    vs_fall   = vsync_dly_q & ~s_vsync;
    vs_rise   = ~vsync_dly_q & s_vsync;
    write_due = pix_valid && (col_q < width_sh_q) && (row_q < depth_sh_q);
    capture_entry = vs_fall && enable_i &&
                    (((state_q == ST_SKIP) && (skip_cnt_q == CNT_WIDTH'(SKIP_FRAMES))) ||
                     (state_q == ST_WAIT_FRAME));
    col_d = col_q;
    if (line_end) begin
      col_d = '0;
    end else if (pix_valid && (col_q != '1)) begin
      col_d = col_q + 1'b1;
    end
    row_d = row_q;
    if (line_end && (row_q != '1)) begin
      row_d = row_q + 1'b1;
    end
  end

  // Capture FSM with registered FIFO strobe, frame pulses and status.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q       <= ST_IDLE;
      skip_cnt_q    <= '0;
      width_sh_q    <= '0;
      depth_sh_q    <= '0;
      col_q         <= '0;
      row_q         <= '0;
      vsync_dly_q   <= 1'b0;
      wr_en_q       <= 1'b0;
      din_q         <= '0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_cnt_q   <= '0;
      overflow_q    <= 1'b0;
    end else begin
      vsync_dly_q   <= s_vsync;
      wr_en_q       <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      if (capture_entry) begin
        state_q       <= ST_CAPTURE;
        frame_start_q <= 1'b1;
        width_sh_q    <= CNT_WIDTH'(resolution_width_i);
        depth_sh_q    <= CNT_WIDTH'(resolution_depth_i);
        col_q         <= '0;
        row_q         <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (enable_i) begin
              state_q    <= ST_SKIP;
              skip_cnt_q <= '0;
            end
          end
          ST_SKIP: begin
            if (!enable_i) begin
              state_q <= ST_IDLE;
            end else if (vs_fall) begin
              skip_cnt_q <= skip_cnt_q + 1'b1;
            end
          end
          ST_WAIT_FRAME: begin
            // Enabled case is taken by capture_entry above.
            if (vs_fall) begin
              state_q <= ST_IDLE;
            end
          end
          ST_CAPTURE: begin
            if (vs_rise) begin
              frame_done_q <= 1'b1;
              frame_cnt_q  <= frame_cnt_q + 1'b1;
              state_q      <= ST_WAIT_FRAME;
            end else begin
              col_q <= col_d;
              row_q <= row_d;
              if (write_due) begin
                if (fifo_cam_full) begin
                  // Rest of the frame is abandoned so the next one starts aligned.
                  overflow_q <= 1'b1;
                  state_q    <= ST_DROP;
                end else begin
                  wr_en_q <= 1'b1;
                  din_q   <= DATA_WIDTH'(pix_data);
                end
              end
            end
          end
          ST_DROP: begin
            if (vs_rise) begin
              state_q <= ST_WAIT_FRAME;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign fifo_cam_wr_en = wr_en_q;
  assign fifo_cam_din   = din_q;
  assign frame_start_o  = frame_start_q;
  assign frame_done_o   = frame_done_q;
  assign frame_cnt_o    = frame_cnt_q;
  assign overflow_o     = overflow_q;
  assign busy_o         = (state_q == ST_CAPTURE) || (state_q == ST_DROP);

endmodule

// File: tb/tb_ov5640_dvp_capture.sv
// Directed bench for ov5640_dvp_capture: two instances (no settle skip and
// two settle frames) driven by a shared DVP sensor model.
module tb_ov5640_dvp_capture;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        en0 = 1'b0;
  logic        en2 = 1'b0;
  logic [15:0] width = 16'd4;
  logic [15:0] depth = 16'd2;
  logic        vsync = 1'b1;
  logic        href = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        full = 1'b0;

  logic        wr0, fs0, fd0, ovf0, busy0;
  logic [15:0] din0, cnt0;
  logic        wr2, fs2, fd2, ovf2, busy2;
  logic [15:0] din2, cnt2;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [15:0] q0[$];
  int nfs0, nfd0, n2, nfs2, nfd2;
  int first_wr_cyc = -1;
  int lo_cyc = -1;

  int full_line = -1;
  int chg_line = -1;
  logic [15:0] chg_width = 16'd0;
  int rst_byte = -1;
  logic [15:0] snap_din2, snap_cnt2, snap_cnt0;
  logic snap_wr2, snap_fs2, snap_fd2, snap_ovf2, snap_busy2, snap_ovf0;

  ov5640_dvp_capture #(.DATA_WIDTH(16), .CNT_WIDTH(16), .SKIP_FRAMES(0)) dut0 (
    .clk_i(clk), .resetn_i(resetn), .enable_i(en0),
    .resolution_width_i(width), .resolution_depth_i(depth),
    .cam_vsync_i(vsync), .cam_href_i(href), .cam_data_i(data),
    .fifo_cam_full(full), .fifo_cam_wr_en(wr0), .fifo_cam_din(din0),
    .frame_start_o(fs0), .frame_done_o(fd0), .frame_cnt_o(cnt0),
    .overflow_o(ovf0), .busy_o(busy0)
  );

  ov5640_dvp_capture #(.DATA_WIDTH(16), .CNT_WIDTH(16), .SKIP_FRAMES(2)) dut2 (
    .clk_i(clk), .resetn_i(resetn), .enable_i(en2),
    .resolution_width_i(width), .resolution_depth_i(depth),
    .cam_vsync_i(vsync), .cam_href_i(href), .cam_data_i(data),
    .fifo_cam_full(full), .fifo_cam_wr_en(wr2), .fifo_cam_din(din2),
    .frame_start_o(fs2), .frame_done_o(fd2), .frame_cnt_o(cnt2),
    .overflow_o(ovf2), .busy_o(busy2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Collect FIFO writes and frame pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (resetn) begin
      if (wr0) begin
        q0.push_back(din0);
        if (first_wr_cyc < 0) first_wr_cyc = cyc;
      end
      if (fs0) nfs0++;
      if (fd0) nfd0++;
      if (wr2) n2++;
      if (fs2) nfs2++;
      if (fd2) nfd2++;
    end
  end

  function automatic logic [7:0] byte_val(logic [7:0] seed, int idx);
    return seed + 8'(idx * 34);
  endfunction

  function automatic logic [15:0] exp_px(logic [7:0] seed, int bpl, int l, int p);
    return {byte_val(seed, l*bpl + 2*p), byte_val(seed, l*bpl + 2*p + 1)};
  endfunction

  task automatic clear_mon();
    q0.delete();
    nfs0 = 0; nfd0 = 0; n2 = 0; nfs2 = 0; nfd2 = 0;
    first_wr_cyc = -1;
  endtask

  // One DVP frame: vsync low, `lines` lines of 2*px+extra bytes, vsync high.
  task automatic send_frame(int lines, int px, int extra, logic [7:0] seed);
    int bpl;
    bpl = 2*px + extra;
    @(negedge clk) vsync = 1'b0;
    repeat (3) @(negedge clk);
    for (int l = 0; l < lines; l++) begin
      if (l == full_line) full = 1'b1;
      if (l == chg_line) width = chg_width;
      for (int b = 0; b < bpl; b++) begin
        @(negedge clk);
        href = 1'b1;
        data = byte_val(seed, l*bpl + b);
        if (l == 0 && b == 1) lo_cyc = cyc + 1;
        if (rst_byte == l*bpl + b) begin
          resetn = 1'b0;
          #1;
          snap_wr2 = wr2; snap_din2 = din2; snap_fs2 = fs2; snap_fd2 = fd2;
          snap_cnt2 = cnt2; snap_ovf2 = ovf2; snap_busy2 = busy2;
          snap_cnt0 = cnt0; snap_ovf0 = ovf0;
        end
      end
      @(negedge clk) href = 1'b0;
      repeat (4) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    vsync = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (wr0 !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b expected 0", wr0); end
    n_checks++; if (din0 !== 16'h0) begin n_fail++; $display("FAIL reset_din: got %h expected 0000", din0); end
    n_checks++; if (fs0 !== 1'b0 || fd0 !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got %b%b expected 00", fs0, fd0); end
    n_checks++; if (cnt0 !== 16'h0) begin n_fail++; $display("FAIL reset_cnt: got %h expected 0000", cnt0); end
    n_checks++; if (ovf0 !== 1'b0 || busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_status: got ovf=%b busy=%b expected 0 0", ovf0, busy0); end
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b expected 0", busy0); end
  endtask

  task automatic test_byte_packing();
    width = 16'd4; depth = 16'd2; en0 = 1'b1;
    repeat (3) @(negedge clk);
    clear_mon();
    send_frame(2, 4, 0, 8'h12);
    $display("pack: %0d writes, start=%0d done=%0d cnt=%0d", q0.size(), nfs0, nfd0, cnt0);
    n_checks++; if (q0.size() != 8) begin n_fail++; $display("FAIL pack_count: got %0d expected 8", q0.size()); end
    if (q0.size() == 8) begin
      n_checks++; if (q0[0] !== 16'h1234) begin n_fail++; $display("FAIL pack_word0: got %h expected 1234", q0[0]); end
      n_checks++; if (q0[1] !== 16'h5678) begin n_fail++; $display("FAIL pack_word1: got %h expected 5678", q0[1]); end
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (q0[i] !== exp_px(8'h12, 8, i/4, i%4)) begin
          n_fail++; $display("FAIL pack_data[%0d]: got %h expected %h", i, q0[i], exp_px(8'h12, 8, i/4, i%4));
        end
      end
    end
    n_checks++; if (nfs0 != 1 || nfd0 != 1) begin n_fail++; $display("FAIL pack_pulses: got start=%0d done=%0d expected 1 1", nfs0, nfd0); end
    n_checks++; if (cnt0 !== 16'd1) begin n_fail++; $display("FAIL pack_frame_cnt: got %0d expected 1", cnt0); end
    n_checks++; if (first_wr_cyc != lo_cyc + 2) begin n_fail++; $display("FAIL pack_latency: got %0d expected %0d", first_wr_cyc - lo_cyc, 2); end
  endtask

  task automatic test_odd_byte();
    clear_mon();
    send_frame(2, 2, 1, 8'h40);
    $display("odd: %0d writes cnt=%0d", q0.size(), cnt0);
    n_checks++; if (q0.size() != 4) begin n_fail++; $display("FAIL odd_count: got %0d expected 4", q0.size()); end
    if (q0.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (q0[i] !== exp_px(8'h40, 5, i/2, i%2)) begin
          n_fail++; $display("FAIL odd_data[%0d]: got %h expected %h", i, q0[i], exp_px(8'h40, 5, i/2, i%2));
        end
      end
    end
    n_checks++; if (cnt0 !== 16'd2) begin n_fail++; $display("FAIL odd_frame_cnt: got %0d expected 2", cnt0); end
  endtask

  task automatic test_crop();
    width = 16'd3; depth = 16'd1;
    clear_mon();
    send_frame(2, 4, 0, 8'hA0);
    $display("crop: %0d writes cnt=%0d", q0.size(), cnt0);
    n_checks++; if (q0.size() != 3) begin n_fail++; $display("FAIL crop_count: got %0d expected 3", q0.size()); end
    if (q0.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (q0[i] !== exp_px(8'hA0, 8, 0, i)) begin
          n_fail++; $display("FAIL crop_data[%0d]: got %h expected %h", i, q0[i], exp_px(8'hA0, 8, 0, i));
        end
      end
    end
    n_checks++; if (cnt0 !== 16'd3) begin n_fail++; $display("FAIL crop_frame_cnt: got %0d expected 3", cnt0); end
    depth = 16'd0;
    clear_mon();
    send_frame(2, 4, 0, 8'h05);
    $display("crop depth0: %0d writes done=%0d cnt=%0d", q0.size(), nfd0, cnt0);
    n_checks++; if (q0.size() != 0) begin n_fail++; $display("FAIL crop_zero_count: got %0d expected 0", q0.size()); end
    n_checks++; if (nfd0 != 1 || cnt0 !== 16'd4) begin n_fail++; $display("FAIL crop_zero_counted: got done=%0d cnt=%0d expected 1 4", nfd0, cnt0); end
  endtask

  task automatic test_overflow();
    width = 16'd4; depth = 16'd2;
    full_line = 1;
    clear_mon();
    send_frame(2, 4, 0, 8'h31);
    full = 1'b0; full_line = -1;
    $display("ovf frame1: %0d writes ovf=%b done=%0d cnt=%0d", q0.size(), ovf0, nfd0, cnt0);
    n_checks++; if (q0.size() != 4) begin n_fail++; $display("FAIL ovf_count: got %0d expected 4", q0.size()); end
    n_checks++; if (ovf0 !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", ovf0); end
    n_checks++; if (nfd0 != 0 || cnt0 !== 16'd4) begin n_fail++; $display("FAIL ovf_no_done: got done=%0d cnt=%0d expected 0 4", nfd0, cnt0); end
    clear_mon();
    send_frame(2, 4, 0, 8'h77);
    $display("ovf frame2: %0d writes start=%0d ovf=%b cnt=%0d", q0.size(), nfs0, ovf0, cnt0);
    n_checks++; if (q0.size() != 8) begin n_fail++; $display("FAIL ovf_recover_count: got %0d expected 8", q0.size()); end
    if (q0.size() == 8) begin
      n_checks++; if (q0[0] !== exp_px(8'h77, 8, 0, 0)) begin n_fail++; $display("FAIL ovf_recover_align: got %h expected %h", q0[0], exp_px(8'h77, 8, 0, 0)); end
    end
    n_checks++; if (nfs0 != 1 || nfd0 != 1) begin n_fail++; $display("FAIL ovf_recover_pulses: got start=%0d done=%0d expected 1 1", nfs0, nfd0); end
    n_checks++; if (ovf0 !== 1'b1 || cnt0 !== 16'd5) begin n_fail++; $display("FAIL ovf_sticky: got ovf=%b cnt=%0d expected 1 5", ovf0, cnt0); end
  endtask

  task automatic test_res_change();
    width = 16'd4; depth = 16'd2;
    chg_line = 1; chg_width = 16'd2;
    clear_mon();
    send_frame(2, 4, 0, 8'h19);
    chg_line = -1;
    $display("reschg frame1: %0d writes", q0.size());
    n_checks++; if (q0.size() != 8) begin n_fail++; $display("FAIL reschg_cur_count: got %0d expected 8", q0.size()); end
    clear_mon();
    send_frame(2, 4, 0, 8'h5A);
    $display("reschg frame2: %0d writes cnt=%0d", q0.size(), cnt0);
    n_checks++; if (q0.size() != 4) begin n_fail++; $display("FAIL reschg_next_count: got %0d expected 4", q0.size()); end
    if (q0.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (q0[i] !== exp_px(8'h5A, 8, i/2, i%2)) begin
          n_fail++; $display("FAIL reschg_data[%0d]: got %h expected %h", i, q0[i], exp_px(8'h5A, 8, i/2, i%2));
        end
      end
    end
    n_checks++; if (cnt0 !== 16'd7) begin n_fail++; $display("FAIL reschg_frame_cnt: got %0d expected 7", cnt0); end
  endtask

  task automatic test_skip();
    width = 16'd4; depth = 16'd2;
    en2 = 1'b1;
    repeat (3) @(negedge clk);
    clear_mon();
    for (int f = 1; f <= 3; f++) begin
      send_frame(2, 4, 0, 8'h21);
      $display("skip frame%0d: %0d writes cnt=%0d", f, n2, cnt2);
      if (f < 3) begin
        n_checks++; if (n2 != 0) begin n_fail++; $display("FAIL skip_frame%0d_writes: got %0d expected 0", f, n2); end
      end
    end
    n_checks++; if (n2 != 8) begin n_fail++; $display("FAIL skip_frame3_writes: got %0d expected 8", n2); end
    n_checks++; if (nfs2 != 1 || nfd2 != 1) begin n_fail++; $display("FAIL skip_pulses: got start=%0d done=%0d expected 1 1", nfs2, nfd2); end
    n_checks++; if (cnt2 !== 16'd1) begin n_fail++; $display("FAIL skip_frame_cnt: got %0d expected 1", cnt2); end
  endtask

  task automatic test_reset_midframe();
    rst_byte = 5;
    send_frame(2, 4, 0, 8'h63);
    rst_byte = -1;
    $display("rst snapshot: wr=%b din=%h fs=%b fd=%b cnt=%0d ovf=%b busy=%b", snap_wr2, snap_din2, snap_fs2, snap_fd2, snap_cnt2, snap_ovf2, snap_busy2);
    n_checks++; if (snap_wr2 !== 1'b0 || snap_fs2 !== 1'b0 || snap_fd2 !== 1'b0) begin n_fail++; $display("FAIL rst_async_strobes: got %b%b%b expected 000", snap_wr2, snap_fs2, snap_fd2); end
    n_checks++; if (snap_din2 !== 16'h0) begin n_fail++; $display("FAIL rst_async_din: got %h expected 0000", snap_din2); end
    n_checks++; if (snap_cnt2 !== 16'h0 || snap_cnt0 !== 16'h0) begin n_fail++; $display("FAIL rst_async_cnt: got %0d/%0d expected 0/0", snap_cnt2, snap_cnt0); end
    n_checks++; if (snap_busy2 !== 1'b0 || snap_ovf2 !== 1'b0 || snap_ovf0 !== 1'b0) begin n_fail++; $display("FAIL rst_async_status: got busy=%b ovf=%b ovf0=%b expected 0 0 0", snap_busy2, snap_ovf2, snap_ovf0); end
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    clear_mon();
    for (int f = 1; f <= 3; f++) begin
      send_frame(2, 4, 0, 8'h0C);
      $display("post-rst frame%0d: %0d writes cnt=%0d", f, n2, cnt2);
      if (f < 3) begin
        n_checks++; if (n2 != 0) begin n_fail++; $display("FAIL rst_skip_frame%0d: got %0d expected 0", f, n2); end
      end
    end
    n_checks++; if (n2 != 8 || cnt2 !== 16'd1) begin n_fail++; $display("FAIL rst_resume: got writes=%0d cnt=%0d expected 8 1", n2, cnt2); end
  endtask

  initial begin
    test_reset();
    test_byte_packing();
    test_odd_byte();
    test_crop();
    test_overflow();
    test_res_change();
    test_skip();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
